// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: splits fields, builds the format-specific immediate and
// flags illegal encodings, then holds results in a main + skid register pair.
module rv32i_decode_stage #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [11:0]         out_funct12,
    output logic [31:0]         out_imm,
    output logic                out_rd_write,
    output logic                out_illegal
);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         inst;
        logic [31:0]         imm;
        logic                rd_write;
        logic                illegal;
    } dec_t;

    dec_t dec, main_q, skid_q;
    logic main_vld, skid_vld, ready_q;
    logic in_fire, writes_rd;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] f12;
    logic [4:0]  rd, rs1;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign f12    = in_inst[31:20];
    assign rd     = in_inst[11:7];
    assign rs1    = in_inst[19:15];

    always_comb begin
        dec.pc      = in_pc;
        dec.inst    = in_inst;
        dec.imm     = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.illegal = 1'b0;
        writes_rd   = 1'b0;
        case (opcode)
            7'h33: begin
                writes_rd   = 1'b1;
                dec.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                writes_rd   = 1'b1;
                dec.illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                              (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h03: begin
                writes_rd   = 1'b1;
                dec.illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            7'h23: begin
                dec.imm     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec.illegal = (f3 > 3'd2);
            end
            7'h37, 7'h17: begin
                writes_rd = 1'b1;
                dec.imm   = {in_inst[31:12], 12'b0};
            end
            7'h6F: begin
                writes_rd = 1'b1;
                dec.imm   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
            end
            7'h67: begin
                writes_rd   = 1'b1;
                dec.illegal = (f3 != 3'd0);
            end
            7'h63: begin
                dec.imm     = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                               in_inst[30:25], in_inst[11:8], 1'b0};
                dec.illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'h73: begin
                // only CSR forms write rd; ECALL/EBREAK need zero rs1/rd
                writes_rd   = (f3 != 3'd0);
                dec.illegal = (f3 == 3'd4) ||
                              (f3 == 3'd0 && (f12 > 12'd1 || rs1 != 5'd0 || rd != 5'd0));
            end
            default: dec.illegal = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11)
            dec.illegal = 1'b1;
        dec.rd_write = writes_rd && (rd != 5'd0) && !dec.illegal;
    end

    assign in_ready = ready_q && !rst;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            ready_q  <= 1'b1;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            if (!main_vld || out_ready) begin
                // main is free or draining this edge: refill from skid first
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                    skid_vld <= 1'b0;
                end else if (in_fire) begin
                    main_q   <= dec;
                    main_vld <= 1'b1;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q   <= dec;
                skid_vld <= 1'b1;
            end
            ready_q <= !(main_vld && !out_ready && (skid_vld || in_fire));
        end
    end

    assign out_valid    = main_vld;
    assign out_pc       = main_q.pc;
    assign out_opcode   = main_q.inst[6:0];
    assign out_rd       = main_q.inst[11:7];
    assign out_rs1      = main_q.inst[19:15];
    assign out_rs2      = main_q.inst[24:20];
    assign out_funct3   = main_q.inst[14:12];
    assign out_funct7   = main_q.inst[31:25];
    assign out_funct12  = main_q.inst[31:20];
    assign out_imm      = main_q.imm;
    assign out_rd_write = main_q.rd_write;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed test-plan steps plus random traffic
// checked against a queue model and an arithmetic decode reference.
module tb_rv32i_decode_stage;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_inst = '0;
    logic        in_ready, out_valid, out_rd_write, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [11:0] out_funct12;

    rv32i_decode_stage #(.PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_funct12(out_funct12),
        .out_imm(out_imm), .out_rd_write(out_rd_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t q[$];
    ent_t pend[$];
    int compared = 0, mismatched = 0;
    logic [31:0] next_pc = 32'h1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned fld(input logic [31:0] x, input int lo, input int w);
        return (int'(x) >> lo) & ((1 << w) - 1);
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        int unsigned op = fld(x, 0, 7);
        int neg = x[31] ? 1 : 0;
        int v;
        if (op == 'h23)
            v = -4096 * neg + fld(x, 25, 7) * 32 + fld(x, 7, 5);
        else if (op == 'h37 || op == 'h17)
            return x & 32'hFFFFF000;
        else if (op == 'h6F)
            v = -(1 << 20) * neg + (fld(x, 12, 8) << 12) + (fld(x, 20, 1) << 11) + (fld(x, 21, 10) << 1);
        else if (op == 'h63)
            v = -4096 * neg + fld(x, 7, 1) * 2048 + fld(x, 25, 6) * 32 + fld(x, 8, 4) * 2;
        else
            v = fld(x, 20, 12) - 4096 * neg;
        return v;
    endfunction

    function automatic logic ref_ill(input logic [31:0] x);
        int unsigned op = fld(x, 0, 7), f3 = fld(x, 12, 3), f7 = fld(x, 25, 7);
        int unsigned f12 = fld(x, 20, 12), rd = fld(x, 7, 5), rs1 = fld(x, 15, 5);
        if (fld(x, 0, 2) != 3) return 1'b1;
        case (op)
            'h33: return !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
            'h13: return (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 'h20));
            'h03: return f3 == 3 || f3 == 6 || f3 == 7;
            'h23: return f3 > 2;
            'h63: return f3 == 2 || f3 == 3;
            'h67: return f3 != 0;
            'h73: return f3 == 4 || (f3 == 0 && (f12 > 1 || rs1 != 0 || rd != 0));
            'h37, 'h17, 'h6F: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ref_wr(input logic [31:0] x);
        int unsigned op = fld(x, 0, 7);
        logic kind = (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h37 ||
                      op == 'h17 || op == 'h6F || op == 'h67 ||
                      (op == 'h73 && fld(x, 12, 3) != 0));
        return kind && fld(x, 7, 5) != 0 && !ref_ill(x);
    endfunction

    function automatic logic [31:0] rand_inst();
        int unsigned ops[10] = '{'h33, 'h13, 'h03, 'h23, 'h37, 'h17, 'h6F, 'h67, 'h63, 'h73};
        logic [31:0] x = $urandom;
        if ($urandom_range(9) < 8) begin
            x[6:0] = 7'(ops[$urandom_range(9)]);
            if ($urandom_range(1) == 1) x[31:25] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
            if (x[6:0] == 7'h73 && $urandom_range(2) == 0) begin
                x[19:7]  = '0;
                x[31:20] = 12'($urandom_range(2));
            end
        end
        return x;
    endfunction

    // One clock: drive inputs, advance the model on the edge, compare on negedge.
    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic r);
        logic rdy_m, in_fire, out_fire;
        logic [31:0] x;
        ent_t e;
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
        rdy_m    = !r && q.size() < 2;
        in_fire  = iv && rdy_m;
        out_fire = q.size() > 0 && ordy;
        @(posedge clk);
        if (r || fl) q.delete();
        else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin e.pc = pc; e.inst = inst; q.push_back(e); end
        end
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(!r && q.size() < 2));
        if (q.size() > 0) begin
            x = q[0].inst;
            check("pc", out_pc, q[0].pc);
            check("opcode", 32'(out_opcode), fld(x, 0, 7));
            check("rd", 32'(out_rd), fld(x, 7, 5));
            check("rs1", 32'(out_rs1), fld(x, 15, 5));
            check("rs2", 32'(out_rs2), fld(x, 20, 5));
            check("funct3", 32'(out_funct3), fld(x, 12, 3));
            check("funct7", 32'(out_funct7), fld(x, 25, 7));
            check("funct12", 32'(out_funct12), fld(x, 20, 12));
            check("imm", out_imm, ref_imm(x));
            check("rd_write", 32'(out_rd_write), 32'(ref_wr(x)));
            check("illegal", 32'(out_illegal), 32'(ref_ill(x)));
        end
        if (r) begin
            check("rst_pc", out_pc, 32'h0);
            check("rst_inst", {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, 32'h0);
            check("rst_imm", out_imm, 32'h0);
            check("rst_flags", {30'h0, out_rd_write, out_illegal}, 32'h0);
        end
    endtask

    task automatic send(input logic [31:0] inst);
        step(1'b1, inst, next_pc, 1'b1, 1'b0, 1'b0);
        next_pc += 4;
    endtask

    task automatic queue_insts(input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.pc = next_pc; e.inst = rand_inst(); next_pc += 4;
            pend.push_back(e);
        end
    endtask

    task automatic pump(input int cycles, input int vpct, input int rpct, input int fpct);
        for (int c = 0; c < cycles; c++) begin
            logic iv, ordy, fl, acc;
            ent_t e;
            iv   = pend.size() > 0 && $urandom_range(99) < vpct;
            ordy = $urandom_range(99) < rpct;
            fl   = $urandom_range(99) < fpct;
            e.pc = '0; e.inst = '0;
            if (iv) e = pend[0];
            acc = iv && q.size() < 2;
            step(iv, e.inst, e.pc, ordy, fl, 1'b0);
            if (acc) void'(pend.pop_front());
        end
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // test-plan decodes, back to back at full rate
        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0);
        check("addi_pc", out_pc, 32'h100);
        check("addi_rd", 32'(out_rd), 32'd1);
        check("addi_rs1", 32'(out_rs1), 32'd0);
        check("addi_imm", out_imm, 32'h5);
        check("addi_wr", 32'(out_rd_write), 32'd1);
        check("addi_ill", 32'(out_illegal), 32'd0);
        send(32'hFE20AE23);
        check("sw_opcode", 32'(out_opcode), 32'h23);
        check("sw_rs1", 32'(out_rs1), 32'd1);
        check("sw_rs2", 32'(out_rs2), 32'd2);
        check("sw_f3", 32'(out_funct3), 32'd2);
        check("sw_imm", out_imm, 32'hFFFFFFFC);
        check("sw_wr", 32'(out_rd_write), 32'd0);
        send(32'hFF9FF06F);
        check("jal_imm", out_imm, 32'hFFFFFFF8);
        check("jal_rd", 32'(out_rd), 32'd0);
        check("jal_wr", 32'(out_rd_write), 32'd0);
        send(32'h123450B7);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_wr", 32'(out_rd_write), 32'd1);
        send(32'h00000000);
        check("zero_ill", 32'(out_illegal), 32'd1);
        send(32'h40001033);
        check("op_f7_ill", 32'(out_illegal), 32'd1);
        send(32'h00002067);
        check("jalr_ill", 32'(out_illegal), 32'd1);
        check("jalr_wr", 32'(out_rd_write), 32'd0);
        pump(3, 100, 100, 0);

        // backpressure: only two fit, then all four drain in order
        queue_insts(4);
        pump(4, 100, 0, 0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_pending", 32'(pend.size()), 32'd2);
        pump(10, 100, 100, 0);
        check("bp_drained", 32'(out_valid), 32'd0);

        // flush with both entries full and a new input in flight
        queue_insts(2);
        pump(3, 100, 0, 0);
        step(1'b1, 32'h00A00113, 32'h2000, 1'b1, 1'b1, 1'b0);
        check("flush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 32'h00100193, 32'h2004, 1'b1, 1'b0, 1'b0);
        check("post_flush_valid", 32'(out_valid), 32'd1);
        check("post_flush_pc", out_pc, 32'h2004);
        pump(3, 100, 100, 0);

        // reset mid-stream
        queue_insts(3);
        pump(2, 100, 0, 0);
        step(1'b1, 32'h00200213, 32'h3000, 1'b1, 1'b0, 1'b1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        pend.delete();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // random traffic with occasional flushes
        queue_insts(300);
        pump(1500, 75, 65, 2);
        pump(400, 100, 100, 0);
        check("rand_all_sent", 32'(pend.size()), 32'd0);
        check("rand_idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
